// File: rtl/arb_pkg.sv
// Shared arbiter definitions: FSM state type and the index-width helper
// used by the arbiter, its interface and the downstream decoder.
package arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

    // Width of a binary index that can address n items; at least one bit.
    function automatic int idx_width(int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_select_arbiter_if.sv
// Request/grant bundle between requesters, the arbiter and the grant consumer.
// With RR_SELECT_ARBITER_ONEHOT_EN defined, it also carries the decoded one-hot grant.
interface rr_select_arbiter_if #(
    parameter int OUTPUT_WIDTH = 4
);
    import arb_pkg::*;

    localparam int IDX_W = idx_width(OUTPUT_WIDTH);

    logic                    enable_i;
    logic [OUTPUT_WIDTH-1:0] req_i;
    logic                    grant_ready_i;
    logic                    grant_valid_o;
    logic [IDX_W-1:0]        grant_idx_o;
`ifdef RR_SELECT_ARBITER_ONEHOT_EN
    logic [OUTPUT_WIDTH-1:0] grant_onehot_o;

    modport slave  (input  enable_i, req_i, grant_ready_i,
                    output grant_valid_o, grant_idx_o, grant_onehot_o);
    modport master (output enable_i, req_i, grant_ready_i,
                    input  grant_valid_o, grant_idx_o, grant_onehot_o);
`else
    modport slave  (input  enable_i, req_i, grant_ready_i,
                    output grant_valid_o, grant_idx_o);
    modport master (output enable_i, req_i, grant_ready_i,
                    input  grant_valid_o, grant_idx_o);
`endif

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin pick: lowest set request bit at or after ptr,
// wrapping around. The request vector is doubled so the wrap becomes a plain
// scan over a window of N bits starting at ptr.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [2*N-1:0] req2;
    logic [2*N-1:0] win_mask;
    logic [2*N-1:0] masked;
    logic           found;

    assign req2 = {req, req};
    assign any  = |req;

    // Window mask selects bits ptr .. ptr+N-1 of the doubled vector.
    always_comb begin
        win_mask = '0;
        for (int i = 0; i < 2*N; i++) begin
            win_mask[i] = (i >= int'(ptr)) && (i < int'(ptr) + N);
        end
    end

    assign masked = req2 & win_mask;

    // First set bit of the masked window, folded back into 0 .. N-1.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < 2*N; i++) begin
            if (!found && masked[i]) begin
                found = 1'b1;
                idx   = IDX_W'((i >= N) ? (i - N) : i);
            end
        end
    end

endmodule

// File: rtl/tree_decoder.sv
// Binary-to-one-hot decoder with enable; only built with RR_SELECT_ARBITER_ONEHOT_EN.
`ifdef RR_SELECT_ARBITER_ONEHOT_EN
module tree_decoder
    import arb_pkg::*;
#(
    parameter int OUTPUT_WIDTH = 4,
    parameter int SEL_W        = idx_width(OUTPUT_WIDTH)
) (
    input  logic                    enable_i,
    input  logic [SEL_W-1:0]        select_i,
    output logic [OUTPUT_WIDTH-1:0] out_o
);

    // One output bit high for the selected index while enabled.
    always_comb begin
        out_o = '0;
        for (int i = 0; i < OUTPUT_WIDTH; i++) begin
            out_o[i] = enable_i && (int'(select_i) == i);
        end
    end

endmodule
`endif

// File: rtl/rr_select_arbiter.sv
// Round-robin arbiter feeding a select/enable decoder. The granted index is
// held under a valid/ready handshake; on accept, the pointer moves past the
// served requester and a new grant may load in the same cycle.
// Optional: RR_SELECT_ARBITER_ONEHOT_EN adds grant_onehot_o via tree_decoder.
module rr_select_arbiter
    import arb_pkg::*;
#(
    parameter int OUTPUT_WIDTH = 4
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    rr_select_arbiter_if.slave bus
);

    localparam int IDX_W = idx_width(OUTPUT_WIDTH);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0] ptr_next;
    logic [IDX_W-1:0] pick_ptr;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic             accept;

    assign accept = (state_q == ARB_GRANT) && bus.grant_ready_i;

    // Pointer after serving the current grant, with explicit wrap for any width.
    always_comb begin
        if (grant_idx_q == IDX_W'(OUTPUT_WIDTH - 1)) begin
            ptr_next = '0;
        end else begin
            ptr_next = grant_idx_q + IDX_W'(1);
        end
        pick_ptr = accept ? ptr_next : ptr_q;
    end

    rr_pick #(
        .N     (OUTPUT_WIDTH),
        .IDX_W (IDX_W)
    ) u_pick (
        .req (bus.req_i),
        .ptr (pick_ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Next state: launch from IDLE, hold under backpressure, reload or drop on accept.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_idx_d = grant_idx_q;
        case (state_q)
            ARB_IDLE: begin
                if (bus.enable_i && pick_any) begin
                    grant_idx_d = pick_idx;
                    state_d     = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                if (bus.grant_ready_i) begin
                    ptr_d = ptr_next;
                    if (bus.enable_i && pick_any) begin
                        grant_idx_d = pick_idx;
                    end else begin
                        state_d = ARB_IDLE;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ARB_IDLE;
            ptr_q       <= '0;
            grant_idx_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so all flops update from pre-edge values.
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_idx_q <= grant_idx_d;
        end
    end

    assign bus.grant_valid_o = (state_q == ARB_GRANT);
    assign bus.grant_idx_o   = grant_idx_q;

`ifdef RR_SELECT_ARBITER_ONEHOT_EN
    tree_decoder #(
        .OUTPUT_WIDTH (OUTPUT_WIDTH)
    ) u_dec (
        .enable_i (bus.grant_valid_o),
        .select_i (grant_idx_q),
        .out_o    (bus.grant_onehot_o)
    );
`endif

endmodule
